// File: rtl/vram_pkg.sv
// Shared types and default sizing for the VRAM arbiter: 1280x500 frame of 6-bit palette indices.
package vram_pkg;

  localparam int VRAM_ADDR_WIDTH = 20;
  localparam int VRAM_DATA_WIDTH = 6;
  localparam int VRAM_DEPTH      = 640000;
  localparam int VRAM_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_PEND = 2'd1,
    RD_RET  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous host write buffer; head entry is visible combinationally for the arbiter.
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int WIDTH = VRAM_ADDR_WIDTH + VRAM_DATA_WIDTH,
  parameter int DEPTH = VRAM_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // A full FIFO refuses the push even when the head pops in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: scan-out reads always win, then a held host read, then buffered host writes.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = VRAM_DATA_WIDTH,
  parameter int DEPTH      = VRAM_DEPTH,
  parameter int FIFO_DEPTH = VRAM_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  vid_valid,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  wr_dropped
);

  localparam int FW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  logic                  fifo_push, fifo_full, fifo_empty;
  logic [FW-1:0]         fifo_head;
  logic [CW-1:0]         fifo_count;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_oor;

  logic                  vid_gnt, rd_gnt, wr_gnt, rd_accept;
  rd_state_t             rd_state_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  ready_en_q;

  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  ram_we_q, ram_we_d;
  logic                  wr_dropped_q, wr_dropped_d;
  logic                  vid_vld_p1_q, vid_valid_q, rd_valid_q;

  // Handshakes stay low until the first edge after reset release.
  assign wr_ready  = ready_en_q && !fifo_full;
  assign rd_ready  = ready_en_q && (rd_state_q == RD_IDLE);
  assign fifo_push = wr_req && wr_ready;
  assign rd_accept = rd_req && rd_ready;

  vram_wr_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (fifo_push),
    .push_data_i ({wr_addr, wr_data}),
    .pop_i       (wr_gnt),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign head_addr = fifo_head[FW-1:DATA_WIDTH];
  assign head_data = fifo_head[DATA_WIDTH-1:0];
  assign head_oor  = ({1'b0, head_addr} >= DEPTH_LIM);

  // The pending read waits for an empty buffer so it can never overtake an older write.
  always_comb begin
    vid_gnt = vid_req;
    rd_gnt  = !vid_req && (rd_state_q == RD_PEND) && (fifo_count == '0);
    wr_gnt  = !vid_req && !rd_gnt && !fifo_empty;
  end

  always_comb begin
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_we_d     = 1'b0;
    wr_dropped_d = 1'b0;
    if (vid_gnt) begin
      ram_addr_d = vid_addr;
    end else if (rd_gnt) begin
      ram_addr_d = rd_addr_q;
    end else if (wr_gnt) begin
      if (head_oor) begin
        wr_dropped_d = 1'b1;
      end else begin
        ram_addr_d  = head_addr;
        ram_wdata_d = head_data;
        ram_we_d    = 1'b1;
      end
    end
  end

  // Stage p0 -> p1: grant lands on the RAM bus; p1 -> p2: RAM output register returns data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      wr_dropped_q <= 1'b0;
      vid_vld_p1_q <= 1'b0;
      vid_valid_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      ready_en_q   <= 1'b1;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
      wr_dropped_q <= wr_dropped_d;
      vid_vld_p1_q <= vid_gnt;
      vid_valid_q  <= vid_vld_p1_q;
      rd_valid_q   <= (rd_state_q == RD_RET);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q <= RD_IDLE;
    end else begin
      case (rd_state_q)
        RD_IDLE: if (rd_accept) rd_state_q <= RD_PEND;
        RD_PEND: if (rd_gnt)    rd_state_q <= RD_RET;
        RD_RET:                 rd_state_q <= RD_IDLE;
        default:                rd_state_q <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rd_accept) rd_addr_q <= rd_addr;
  end

  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign wr_dropped = wr_dropped_q;
  assign vid_valid  = vid_valid_q;
  assign rd_valid   = rd_valid_q;
  // Read data comes straight from the RAM's own output register.
  assign vid_data   = ram_rdata;
  assign rd_data    = ram_rdata;

endmodule
